// File: rtl/axis_crc24_check.sv
// ---------------------------------------------------------------------------
// axis_crc24_check
//
// Receive-side CRC-24 checker for an 8-bit AXI-Stream link. Each frame is a
// run of payload bytes followed by 3 CRC bytes (MSB first), with tlast on the
// last CRC byte. The CRC runs over every byte of the frame, and a zero residue
// after the tlast byte means the frame passed.
//
// The payload is forwarded with the CRC bytes stripped. A 3-byte delay line
// holds back the most recent bytes, so the CRC trailer is never emitted.
// tlast moves to the last payload byte, and m_tuser flags a CRC failure on
// that beat.
//
// Ports
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   s_tdata/s_tvalid/   upstream stream (payload + CRC bytes)
//   s_tlast/s_tready
//   m_tdata/m_tvalid/   downstream stream (payload only)
//   m_tlast/m_tuser/
//   m_tready
//   frame_ok/frame_err  one-cycle frame result pulses
//   ok_cnt/err_cnt      saturating pass/fail frame counters
// ---------------------------------------------------------------------------
module axis_crc24_check #(
    parameter int          N     = 8,
    parameter logic [23:0] POLY  = 24'h864CFB,
    parameter logic [23:0] INIT  = 24'h000000,
    parameter int          CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     s_tdata,
    input  logic             s_tvalid,
    input  logic             s_tlast,
    output logic             s_tready,
    output logic [N-1:0]     m_tdata,
    output logic             m_tvalid,
    output logic             m_tlast,
    output logic             m_tuser,
    input  logic             m_tready,
    output logic             frame_ok,
    output logic             frame_err,
    output logic [CNT_W-1:0] ok_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    logic [23:0]  crc_r;
    logic [23:0]  crc_next;
    logic [N-1:0] sr0, sr1, sr2;   // sr0 newest, sr2 oldest
    logic [1:0]   fill;
    logic         accept;
    logic         full;

    // Eight MSB-first polynomial-division steps folded into one cycle.
    function automatic logic [23:0] crc_byte(input logic [23:0] c, input logic [N-1:0] d);
        logic [23:0] r;
        r = c;
        for (int i = N - 1; i >= 0; i--) begin
            if (r[23] ^ d[i])
                r = {r[22:0], 1'b0} ^ POLY;
            else
                r = {r[22:0], 1'b0};
        end
        return r;
    endfunction

    assign s_tready = m_tready || !m_tvalid;
    assign accept   = s_tvalid && s_tready;
    assign full     = (fill == 2'd3);
    assign crc_next = crc_byte(crc_r, s_tdata);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_r     <= INIT;
            sr0       <= '0;
            sr1       <= '0;
            sr2       <= '0;
            fill      <= 2'd0;
            m_tdata   <= '0;
            m_tvalid  <= 1'b0;
            m_tlast   <= 1'b0;
            m_tuser   <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            ok_cnt    <= '0;
            err_cnt   <= '0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;

            if (m_tvalid && m_tready)
                m_tvalid <= 1'b0;

            if (accept) begin
                sr2 <= sr1;
                sr1 <= sr0;
                sr0 <= s_tdata;

                // A full delay line evicts its oldest byte. s_tready guarantees
                // that the output register is free, or is draining this cycle.
                if (full) begin
                    m_tdata  <= sr2;
                    m_tvalid <= 1'b1;
                    m_tlast  <= s_tlast;
                    m_tuser  <= s_tlast && (crc_next != 24'd0);
                end

                if (s_tlast) begin
                    // The held bytes are the CRC trailer; drop them with the frame state.
                    fill  <= 2'd0;
                    crc_r <= INIT;
                    if (full && crc_next == 24'd0) begin
                        frame_ok <= 1'b1;
                        if (ok_cnt != {CNT_W{1'b1}})
                            ok_cnt <= ok_cnt + 1'b1;
                    end else begin
                        // A CRC failure, or a runt frame that ends before the line is full.
                        frame_err <= 1'b1;
                        if (err_cnt != {CNT_W{1'b1}})
                            err_cnt <= err_cnt + 1'b1;
                    end
                end else begin
                    crc_r <= crc_next;
                    if (!full)
                        fill <= fill + 2'd1;
                end
            end
        end
    end

endmodule
